key_tone_gen: RTL and testbench

//  Consumes the 4-bit key code (0 = no key, 1..9 = note keys) from the keypad

---
 rtl/key_tone_gen.sv | 137 +++++++++++++
 tb/tb_key_tone_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_tone_gen.sv
// Keypad note player: debounces a 4-bit key code and drives the speaker pin
// with a 50% duty square wave whose half-period is looked up per note.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no note accepted; speaker held low, half-period counter held at 0
// S_PLAY | accepted nonzero code; speaker toggles every HALF[code] cycles
module key_tone_gen #(
  parameter int CLK_HZ     = 1_000_000,
  parameter int STABLE_CYC = 16,
  parameter int DIV_W      = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] KEY,
  output logic       SPKOUT,
  output logic       ACTIVE,
  output logic [3:0] TONE_IDX,
  output logic [7:0] NOTE_CNT
);

  localparam int STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);

  // Terminal counts are HALF-1 so the counter wraps after exactly HALF cycles.
  localparam logic [DIV_W-1:0] HM1_1 = DIV_W'(CLK_HZ / (2 * 262) - 1);
  localparam logic [DIV_W-1:0] HM1_2 = DIV_W'(CLK_HZ / (2 * 294) - 1);
  localparam logic [DIV_W-1:0] HM1_3 = DIV_W'(CLK_HZ / (2 * 330) - 1);
  localparam logic [DIV_W-1:0] HM1_4 = DIV_W'(CLK_HZ / (2 * 349) - 1);
  localparam logic [DIV_W-1:0] HM1_5 = DIV_W'(CLK_HZ / (2 * 392) - 1);
  localparam logic [DIV_W-1:0] HM1_6 = DIV_W'(CLK_HZ / (2 * 440) - 1);
  localparam logic [DIV_W-1:0] HM1_7 = DIV_W'(CLK_HZ / (2 * 494) - 1);
  localparam logic [DIV_W-1:0] HM1_8 = DIV_W'(CLK_HZ / (2 * 523) - 1);
  localparam logic [DIV_W-1:0] HM1_9 = DIV_W'(CLK_HZ / (2 * 587) - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t            state_q;
  logic [3:0]        key_q;
  logic [3:0]        cand_q;
  logic [STAB_W-1:0] stab_q;
  logic [3:0]        tone_q;
  logic [DIV_W-1:0]  hc_q;
  logic              spk_q;
  logic              active_q;
  logic [7:0]        cnt_q;

  logic [3:0]        key_d;
  logic [DIV_W-1:0]  half_m1_d;
  logic              commit_d;

  always_comb begin
    key_d = (KEY <= 4'd9) ? KEY : 4'd0;
  end

  always_comb begin
    half_m1_d = '0;
    case (tone_q)
      4'd1:    half_m1_d = HM1_1;
      4'd2:    half_m1_d = HM1_2;
      4'd3:    half_m1_d = HM1_3;
      4'd4:    half_m1_d = HM1_4;
      4'd5:    half_m1_d = HM1_5;
      4'd6:    half_m1_d = HM1_6;
      4'd7:    half_m1_d = HM1_7;
      4'd8:    half_m1_d = HM1_8;
      4'd9:    half_m1_d = HM1_9;
      default: half_m1_d = '0;
    endcase
  end

  always_comb begin
    commit_d = (stab_q == STAB_MAX) && (cand_q == key_q) && (cand_q != tone_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      cand_q   <= '0;
      stab_q   <= '0;
      tone_q   <= '0;
      hc_q     <= '0;
      spk_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      key_q <= key_d;

      // Any change of the registered code restarts the stability window.
      if (key_q != cand_q) begin
        cand_q <= key_q;
        stab_q <= '0;
      end else if (stab_q != STAB_MAX) begin
        stab_q <= stab_q + STAB_W'(1);
      end

      if (commit_d) begin
        tone_q <= cand_q;
        hc_q   <= '0;
        spk_q  <= 1'b0;
        if (cand_q == 4'd0) begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end else begin
          state_q  <= S_PLAY;
          active_q <= 1'b1;
          cnt_q    <= cnt_q + 8'd1;
        end
      end else begin
        case (state_q)
          S_PLAY: begin
            if (hc_q == half_m1_d) begin
              hc_q  <= '0;
              spk_q <= ~spk_q;
            end else begin
              hc_q <= hc_q + DIV_W'(1);
            end
          end
          default: begin
            hc_q  <= '0;
            spk_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SPKOUT   = spk_q;
  assign ACTIVE   = active_q;
  assign TONE_IDX = tone_q;
  assign NOTE_CNT = cnt_q;

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed bench for key_tone_gen at 1 MHz with a 4-cycle stability window.
module tb_key_tone_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] KEY;
  logic       SPKOUT;
  logic       ACTIVE;
  logic [3:0] TONE_IDX;
  logic [7:0] NOTE_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  key_tone_gen #(
    .CLK_HZ    (1_000_000),
    .STABLE_CYC(4),
    .DIV_W     (16)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .KEY     (KEY),
    .SPKOUT  (SPKOUT),
    .ACTIVE  (ACTIVE),
    .TONE_IDX(TONE_IDX),
    .NOTE_CNT(NOTE_CNT)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic spk, input logic act,
                         input logic [3:0] tone, input logic [7:0] cnt);
    chk({tag, ".spk"},  {31'd0, SPKOUT}, {31'd0, spk});
    chk({tag, ".act"},  {31'd0, ACTIVE}, {31'd0, act});
    chk({tag, ".tone"}, {28'd0, TONE_IDX}, {28'd0, tone});
    chk({tag, ".cnt"},  {24'd0, NOTE_CNT}, {24'd0, cnt});
  endtask

  initial begin
    RST = 1'b1;
    KEY = 4'd6;
    step(1);
    chk_all("rst_e1", 1'b0, 1'b0, 4'd0, 8'd0);
    step(1);
    chk_all("rst_e2", 1'b0, 1'b0, 4'd0, 8'd0);

    // Release: key 6 commits on the 6th edge.
    RST = 1'b0;
    step(5);
    chk_all("pre_commit6", 1'b0, 1'b0, 4'd0, 8'd0);
    step(1);
    chk_all("commit6", 1'b0, 1'b1, 4'd6, 8'd1);

    // HALF[6] = 1136: first rise 1136 edges after commit, then 50% duty.
    step(1135);
    chk("k6_before_rise", {31'd0, SPKOUT}, 32'd0);
    step(1);
    chk("k6_rise", {31'd0, SPKOUT}, 32'd1);
    step(1135);
    chk("k6_high_end", {31'd0, SPKOUT}, 32'd1);
    step(1);
    chk("k6_fall", {31'd0, SPKOUT}, 32'd0);
    step(1135);
    chk("k6_low_end", {31'd0, SPKOUT}, 32'd0);
    step(1);
    chk("k6_rise2", {31'd0, SPKOUT}, 32'd1);

    // Brief glitch to 0 then 6 again: not a new commit.
    KEY = 4'd0;
    step(2);
    KEY = 4'd6;
    step(10);
    chk("reprs_tone", {28'd0, TONE_IDX}, 32'd6);
    chk("reprs_act", {31'd0, ACTIVE}, 32'd1);
    chk("reprs_cnt", {24'd0, NOTE_CNT}, 32'd1);

    // Release to 0: IDLE after 6 edges.
    KEY = 4'd0;
    step(5);
    chk("rel_pre_act", {31'd0, ACTIVE}, 32'd1);
    step(1);
    chk_all("rel_idle", 1'b0, 1'b0, 4'd0, 8'd1);

    // Short press of 3 for 3 cycles is rejected.
    KEY = 4'd3;
    step(3);
    KEY = 4'd0;
    step(10);
    chk_all("short3", 1'b0, 1'b0, 4'd0, 8'd1);

    // Out-of-range code maps to silence.
    KEY = 4'd12;
    step(10);
    chk_all("code12_idle", 1'b0, 1'b0, 4'd0, 8'd1);

    // Play 1, switch to 9 mid half-period.
    KEY = 4'd1;
    step(6);
    chk_all("commit1", 1'b0, 1'b1, 4'd1, 8'd2);
    step(500);
    KEY = 4'd9;
    step(5);
    chk("pre_commit9", {28'd0, TONE_IDX}, 32'd1);
    step(1);
    chk_all("commit9", 1'b0, 1'b1, 4'd9, 8'd3);
    step(850);
    chk("k9_before_rise", {31'd0, SPKOUT}, 32'd0);
    step(1);
    chk("k9_rise", {31'd0, SPKOUT}, 32'd1);
    step(850);
    chk("k9_high_end", {31'd0, SPKOUT}, 32'd1);
    step(1);
    chk("k9_fall", {31'd0, SPKOUT}, 32'd0);

    // Play 5, wait until speaker is high, then code 12 silences it.
    KEY = 4'd5;
    step(6);
    chk_all("commit5", 1'b0, 1'b1, 4'd5, 8'd4);
    step(1280);
    chk("k5_high", {31'd0, SPKOUT}, 32'd1);
    KEY = 4'd12;
    step(5);
    chk("k12_pre_act", {31'd0, ACTIVE}, 32'd1);
    step(1);
    chk_all("k12_idle", 1'b0, 1'b0, 4'd0, 8'd4);

    // Count wrap: 252 more presses of 2 bring 4 back to 0.
    for (int i = 0; i < 252; i++) begin
      KEY = 4'd2;
      step(6);
      if (i == 0)   chk("wrap_cnt5",   {24'd0, NOTE_CNT}, 32'd5);
      if (i == 250) chk("wrap_cnt255", {24'd0, NOTE_CNT}, 32'd255);
      KEY = 4'd0;
      step(6);
    end
    chk_all("wrap_cnt0", 1'b0, 1'b0, 4'd0, 8'd0);

    // Reset mid-note with the speaker high, then replay of the held key.
    KEY = 4'd2;
    step(6);
    chk_all("commit2", 1'b0, 1'b1, 4'd2, 8'd1);
    step(1750);
    chk("k2_high", {31'd0, SPKOUT}, 32'd1);
    RST = 1'b1;
    step(1);
    chk_all("midrst", 1'b0, 1'b0, 4'd0, 8'd0);
    RST = 1'b0;
    step(5);
    chk_all("replay_pre", 1'b0, 1'b0, 4'd0, 8'd0);
    step(1);
    chk_all("replay", 1'b0, 1'b1, 4'd2, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
